// File: rtl/trigger_srl_bank.sv
// trigger_srl_bank: run-time reprogrammable shift-register truth-table trigger matcher
module trigger_srl_bank #(
  parameter int CHANNELS = 8,
  parameter int IDX_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  input  logic                trig_en,
  input  logic                trig_mode,
  input  logic                cfg_wr,
  input  logic [IDX_W-1:0]    cfg_index,
  input  logic [31:0]         cfg_data,
  output logic                cfg_busy,
  output logic                tables_valid,
  output logic                trig
);
  localparam int NUM_SRL = (CHANNELS + 1) / 2;
  localparam int CH_P = 2 * NUM_SRL;
  localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_SRL);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [CH_P-1:0] cur, old;
  logic [31:0] word;
  logic [IDX_W-1:0] idx;
  logic [4:0] cnt;
  logic [2**IDX_W-1:0] valid;
  logic [NUM_SRL-1:0] q;
  logic accept, last;
  always_comb begin
    last = state == SHIFT && cnt == 5'd0;
    accept = cfg_wr && {1'b0, cfg_index} < NUM_L && (state == IDLE || last);
    state_nx = accept ? SHIFT : last ? IDLE : state;
  end
  assign cfg_busy = state == SHIFT;
  assign tables_valid = &valid[NUM_SRL-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      cur <= '0;
      old <= '0;
      trig <= 1'b0;
    end else begin
      state <= state_nx;
      cur <= CH_P'(din);
      old <= cur;
      if (last) valid[idx] <= 1'b1;
      if (accept) valid[cfg_index] <= 1'b0;
      trig <= trig_en & tables_valid & ~cfg_busy & (trig_mode ? |q : &q);
    end
  end
  always_ff @(posedge clk) begin
    cnt <= accept ? 5'd31 : cnt - 5'(cfg_busy);
    if (accept) begin
      word <= cfg_data;
      idx <= cfg_index;
    end
  end
  for (genvar k = 0; k < NUM_SRL; k++) begin : g_srl
    logic [31:0] sr;
    always_ff @(posedge clk)
      if (rst_n && cfg_busy && idx == IDX_W'(k)) sr <= {sr[30:0], word[cnt]};
    assign q[k] = sr[{1'b0, old[2*k+1], cur[2*k+1], old[2*k], cur[2*k]}];
  end
endmodule

// File: tb/tb_trigger_srl_bank.sv
// tb_trigger_srl_bank: directed vector bench for trigger_srl_bank at 4 and 3 channels
module tb_trigger_srl_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig_en = 1'b0;
  logic trig_mode = 1'b0;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_index = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic [3:0] din4 = 4'd0;
  logic [2:0] din3 = 3'd0;
  logic busy4, valid4, trig4, busy3, valid3, trig3;
  int nvec = 0;
  int nerr = 0;
  typedef struct packed {
    logic [3:0] d4;
    logic [2:0] d3;
    logic en;
    logic mode;
    logic e4;
    logic e3;
  } vec_t;
  vec_t v [32];
  always #5 clk = ~clk;
  trigger_srl_bank #(.CHANNELS(4), .IDX_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .trig_en(trig_en), .trig_mode(trig_mode),
    .cfg_wr(cfg_wr), .cfg_index(cfg_index), .cfg_data(cfg_data),
    .cfg_busy(busy4), .tables_valid(valid4), .trig(trig4)
  );
  trigger_srl_bank #(.CHANNELS(3), .IDX_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .trig_en(trig_en), .trig_mode(trig_mode),
    .cfg_wr(cfg_wr), .cfg_index(cfg_index), .cfg_data(cfg_data),
    .cfg_busy(busy3), .tables_valid(valid3), .trig(trig3)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic load(input logic [1:0] i, input logic [31:0] d);
    cfg_wr = 1'b1;
    cfg_index = i;
    cfg_data = d;
    tick;
    cfg_wr = 1'b0;
    repeat (32) tick;
  endtask
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      din4 = v[i].d4;
      din3 = v[i].d3;
      trig_en = v[i].en;
      trig_mode = v[i].mode;
      tick;
      chk($sformatf("vec%0d_trig4", i), trig4, v[i].e4);
      chk($sformatf("vec%0d_trig3", i), trig3, v[i].e3);
    end
  endtask
  initial begin
    int busy_n;
    v[0]  = {4'h0, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[1]  = {4'h1, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[2]  = {4'h1, 3'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    v[3]  = {4'h1, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[4]  = {4'h1, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[5]  = {4'h0, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[6]  = {4'h1, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[7]  = {4'h1, 3'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    v[8]  = {4'hE, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[9]  = {4'hF, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[10] = {4'hF, 3'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    v[11] = {4'h0, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[12] = {4'h1, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[13] = {4'h1, 3'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[14] = {4'h0, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[15] = {4'h4, 3'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    v[16] = {4'h4, 3'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    v[17] = {4'h4, 3'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    v[18] = {4'h0, 3'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    v[19] = {4'h0, 3'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    v[20] = {4'h6, 3'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    v[21] = {4'h6, 3'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    v[22] = {4'h6, 3'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[23] = {4'h6, 3'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    v[24] = {4'h0, 3'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    v[25] = {4'hC, 3'h4, 1'b1, 1'b1, 1'b0, 1'b0};
    v[26] = {4'hC, 3'h4, 1'b1, 1'b1, 1'b0, 1'b1};
    v[27] = {4'hC, 3'h4, 1'b1, 1'b1, 1'b0, 1'b0};
    v[28] = {4'h0, 3'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    v[29] = {4'h4, 3'h6, 1'b1, 1'b1, 1'b0, 1'b0};
    v[30] = {4'h4, 3'h6, 1'b1, 1'b1, 1'b1, 1'b1};
    v[31] = {4'h4, 3'h6, 1'b1, 1'b1, 1'b0, 1'b0};
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    cfg_wr = 1'b1;
    cfg_index = 2'd0;
    cfg_data = 32'hFFFF_FFFF;
    tick;
    cfg_wr = 1'b0;
    repeat (5) tick;
    chk("busy_mid_load", busy4, 1'b1);
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    trig_en = 1'b1;
    tick;
    chk("rst_trig", trig4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_valid", valid4, 1'b0);
    chk("rst_valid3", valid3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("post_rst_trig%0d", i), trig4, 1'b0);
    end
    cfg_wr = 1'b1;
    cfg_index = 2'd0;
    cfg_data = 32'h0000_2222;
    tick;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      busy_n += int'(busy4);
      cfg_wr = i == 9;
      cfg_data = 32'hFFFF_FFFF;
      tick;
    end
    cfg_wr = 1'b0;
    chk("busy_32_cycles", busy_n == 32, 1'b1);
    chk("busy_done", busy4, 1'b0);
    chk("one_table_valid", valid4, 1'b0);
    cfg_wr = 1'b1;
    cfg_index = 2'd2;
    tick;
    cfg_wr = 1'b0;
    chk("oob_busy", busy4, 1'b0);
    load(2'd1, 32'h0000_FFFF);
    chk("tables_valid", valid4, 1'b1);
    chk("tables_valid3", valid3, 1'b1);
    run_vecs(0, 14);
    load(2'd0, 32'h0000_0000);
    load(2'd1, 32'h0000_AAAA);
    run_vecs(15, 23);
    cfg_wr = 1'b1;
    cfg_index = 2'd1;
    cfg_data = 32'h0000_AAAA;
    tick;
    cfg_wr = 1'b0;
    chk("sup_accept_edge", trig4, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      tick;
      chk($sformatf("sup_a+%0d", i), trig4, 1'b0);
    end
    tick;
    chk("sup_a+33", trig4, 1'b1);
    cfg_wr = 1'b1;
    cfg_index = 2'd0;
    cfg_data = 32'h0000_0000;
    tick;
    cfg_wr = 1'b0;
    repeat (31) tick;
    cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
    chk("b2b_busy", busy4, 1'b1);
    chk("b2b_valid", valid4, 1'b0);
    repeat (31) tick;
    chk("b2b_busy_end", busy4, 1'b1);
    tick;
    chk("b2b_idle", busy4, 1'b0);
    chk("b2b_valid_end", valid4, 1'b1);
    din4 = 4'h0;
    din3 = 3'h0;
    load(2'd1, 32'h0000_0002);
    run_vecs(24, 31);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
